// File: rtl/core_memory_responder.sv
// core_memory_responder: shared word RAM serving an instruction bus and a data bus with wait states, byte lanes and alternating arbitration.
module core_memory_responder #(
  parameter int addr_bits = 10,
  parameter int wait_states = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_out,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_in,
  output logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RECOVER} state_t;
  state_t state, state_nx;
  logic [15:0] ram [2**addr_bits];
  logic [addr_bits-1:0] addr;
  logic [15:0] wdata;
  logic [1:0] bytesel;
  logic [3:0] cnt;
  logic wr_en, grant, last_grant, req, grant_nx, done;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_m_addr[19:addr_bits+1], data_m_addr[19:addr_bits+1]};
  assign req = instr_m_access | data_m_access;
  // grant = 1 selects the data bus; a tie goes to whichever port did not win last
  assign grant_nx = data_m_access & (~instr_m_access | ~last_grant);
  assign done = state == WAIT && cnt == 4'd0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? WAIT : IDLE;
      WAIT:    state_nx = cnt == 4'd0 ? ACK : WAIT;
      ACK:     state_nx = RECOVER;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      last_grant <= 1'b0;
      grant <= 1'b0;
      addr <= '0;
      wdata <= 16'h0000;
      wr_en <= 1'b0;
      bytesel <= 2'b00;
      instr_m_ack <= 1'b0;
      data_m_ack <= 1'b0;
      instr_m_data_out <= 16'h0000;
      data_m_data_out <= 16'h0000;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        grant <= grant_nx;
        addr <= grant_nx ? data_m_addr[addr_bits:1] : instr_m_addr[addr_bits:1];
        wr_en <= grant_nx & data_m_wr_en;
        bytesel <= data_m_bytesel;
        wdata <= data_m_data_in;
        cnt <= 4'(wait_states);
      end
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      instr_m_ack <= done & ~grant;
      data_m_ack <= done & grant;
      if (done & ~wr_en & grant) data_m_data_out <= ram[addr];
      if (done & ~wr_en & ~grant) instr_m_data_out <= ram[addr];
      if (state == ACK) last_grant <= grant;
    end
  end
  // RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (done & wr_en & bytesel[0]) ram[addr][7:0] <= wdata[7:0];
    if (done & wr_en & bytesel[1]) ram[addr][15:8] <= wdata[15:8];
  end
endmodule

// File: tb/tb_core_memory_responder.sv
// tb_core_memory_responder: scoreboard bench for core_memory_responder (wait_states 1 main instance, wait_states 0 side instance).
module tb_core_memory_responder;
  logic clk = 1'b0, reset = 1'b1;
  logic [19:1] instr_m_addr = '0, data_m_addr = '0;
  logic instr_m_access = 1'b0, data_m_access = 1'b0, data_m_wr_en = 1'b0;
  logic [15:0] data_m_data_in = '0;
  logic [1:0] data_m_bytesel = '0;
  logic instr_m_ack, data_m_ack;
  logic [15:0] instr_m_data_out, data_m_data_out;
  logic [19:1] z_iaddr = '0, z_daddr = '0;
  logic z_iacc = 1'b0, z_dacc = 1'b0, z_we = 1'b0;
  logic [15:0] z_din = '0;
  logic [1:0] z_bs = '0;
  logic z_iack, z_dack;
  logic [15:0] z_idata, z_ddata;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic port; logic rd; logic [15:0] data; int cyc;} exp_t;
  exp_t sb[$];
  exp_t e;

  core_memory_responder #(.addr_bits(10), .wait_states(1)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_out(instr_m_data_out),
    .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
    .data_m_data_out(data_m_data_out), .data_m_access(data_m_access),
    .data_m_ack(data_m_ack), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel)
  );

  core_memory_responder #(.addr_bits(10), .wait_states(0)) dut_z (
    .clk(clk), .reset(reset),
    .instr_m_addr(z_iaddr), .instr_m_access(z_iacc),
    .instr_m_ack(z_iack), .instr_m_data_out(z_idata),
    .data_m_addr(z_daddr), .data_m_data_in(z_din),
    .data_m_data_out(z_ddata), .data_m_access(z_dacc),
    .data_m_ack(z_dack), .data_m_wr_en(z_we),
    .data_m_bytesel(z_bs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!reset && (data_m_ack || instr_m_ack)) begin
      check("dual_ack", {31'd0, data_m_ack & instr_m_ack}, 0);
      if (sb.size() == 0) check("spurious_ack", {instr_m_ack, data_m_ack}, 0);
      else begin
        e = sb.pop_front();
        check("ack_port", {31'd0, data_m_ack}, {31'd0, e.port});
        check("ack_cycle", cyc, e.cyc);
        if (e.rd) check("rd_data", e.port ? data_m_data_out : instr_m_data_out, e.data);
      end
    end
  end

  task automatic data_op(input logic [19:1] a, input logic [15:0] d, input logic we,
                         input logic [1:0] bs, input logic [15:0] exp);
    @(negedge clk);
    data_m_addr = a; data_m_data_in = d; data_m_wr_en = we; data_m_bytesel = bs;
    data_m_access = 1'b1;
    sb.push_back('{1'b1, !we, exp, cyc + 3});
    for (int i = 0; i < 20 && !data_m_ack; i++) @(negedge clk);
    if (!data_m_ack) check("ack_timeout", {31'd0, data_m_ack}, 1);
    @(negedge clk);
    data_m_access = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_iack", {31'd0, instr_m_ack}, 0);
    check("rst_dack", {31'd0, data_m_ack}, 0);
    check("rst_idata", instr_m_data_out, 0);
    check("rst_ddata", data_m_data_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    data_op(19'h00010, 16'hBEEF, 1'b1, 2'b11, 16'h0000);
    data_op(19'h00010, 16'h0000, 1'b0, 2'b11, 16'hBEEF);
    data_op(19'h00010, 16'h12AA, 1'b1, 2'b01, 16'h0000);
    data_op(19'h00010, 16'h0000, 1'b0, 2'b11, 16'hBEAA);
    data_op(19'h00010, 16'h1234, 1'b1, 2'b00, 16'h0000);
    data_op(19'h00010, 16'h0000, 1'b0, 2'b11, 16'hBEAA);
    data_op(19'h00005, 16'h5555, 1'b1, 2'b11, 16'h0000);
    data_op(19'h00405, 16'h0000, 1'b0, 2'b11, 16'h5555);
    data_op(19'h00030, 16'h0001, 1'b1, 2'b11, 16'h0000);
    // reset lands while the FFFF write is still waiting
    @(negedge clk);
    data_m_addr = 19'h00030; data_m_data_in = 16'hFFFF; data_m_wr_en = 1'b1;
    data_m_bytesel = 2'b11; data_m_access = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_dack", {31'd0, data_m_ack}, 0);
    check("mid_rst_iack", {31'd0, instr_m_ack}, 0);
    check("mid_rst_ddata", data_m_data_out, 0);
    @(negedge clk);
    data_m_access = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    data_op(19'h00030, 16'h0000, 1'b0, 2'b11, 16'h0001);
    // tie: last_grant back at instruction, so data, instr, data
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    data_m_addr = 19'h00030; data_m_wr_en = 1'b0; data_m_access = 1'b1;
    instr_m_addr = 19'h00010; instr_m_access = 1'b1;
    sb.push_back('{1'b1, 1'b1, 16'h0001, cyc + 3});
    sb.push_back('{1'b0, 1'b1, 16'hBEAA, cyc + 8});
    sb.push_back('{1'b1, 1'b1, 16'h0001, cyc + 13});
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("tie_timeout", sb.size(), 0);
    data_m_access = 1'b0; instr_m_access = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_ddata", data_m_data_out, 16'h0001);
    check("hold_idata", instr_m_data_out, 16'hBEAA);
    @(negedge clk);
    z_daddr = 19'h00020; z_din = 16'h9090; z_we = 1'b1; z_bs = 2'b11; z_dacc = 1'b1;
    repeat (2) @(negedge clk);
    check("z_wr_ack", {31'd0, z_dack}, 1);
    @(negedge clk) z_dacc = 1'b0;
    @(negedge clk);
    z_iaddr = 19'h00020; z_iacc = 1'b1;
    @(negedge clk);
    check("z_rd_early", {31'd0, z_iack}, 0);
    @(negedge clk);
    check("z_iack", {31'd0, z_iack}, 1);
    check("z_dack_quiet", {31'd0, z_dack}, 0);
    check("z_idata", z_idata, 16'h9090);
    @(negedge clk);
    z_iacc = 1'b0;
    check("z_iack_pulse", {31'd0, z_iack}, 0);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/core_memory_responder.md
# core_memory_responder

Responder-side model of the core's instruction and data memory buses, used as the memory behind the core in simulation and small FPGA builds. Serves the read-only instruction bus and the read/write data bus from one shared word-addressed RAM. Provides programmable wait states, byte-lane writes and fair arbitration when both buses request in the same cycle.

## Interface
- addr_bits, default 10: word-address bits actually decoded; the RAM holds 2^addr_bits 16-bit words.
- wait_states, default 1, range 0..15: extra cycles inserted before each ack.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all control state.
- instr_m_addr  in  19  word address [19:1] from the instruction fetcher.
- instr_m_access  in  1  instruction read request; held until ack.
- instr_m_ack  out  1  one-cycle completion pulse for the instruction bus.
- instr_m_data_out  out  16  instruction read data.
- data_m_addr  in  19  word address [19:1] for data accesses.
- data_m_data_in  in  16  write data from the core.
- data_m_data_out  out  16  read data to the core.
- data_m_access  in  1  data request; held until ack.
- data_m_ack  out  1  one-cycle completion pulse for the data bus.
- data_m_wr_en  in  1  1 = write, 0 = read.
- data_m_bytesel  in  2  byte lanes; bit0 = [7:0], bit1 = [15:8].

## Operation
- FSM states: IDLE, WAIT, ACK, RECOVER. Reset state is IDLE.
- IDLE, with at least one access high: grant a port.
  - Latch the granted port's address, wr_en, bytesel and write data. The instruction bus is always a read.
  - Load the wait counter with wait_states and go to WAIT.
  - With no request, stay in IDLE.
- Arbitration:
  - A single requester is granted.
  - If both request, grant the port that was not granted last.
  - last_grant resets to instruction, so data wins the first tie.
- WAIT:
  - If the counter is 0, go to ACK. Otherwise decrement it and stay in WAIT.
  - On the edge leaving WAIT:
    - A write updates only the lanes selected in bytesel.
    - A read loads the RAM word into the granted port's data_out register.
- ACK:
  - The granted port's ack is 1 for exactly this cycle; its data_out is valid.
  - The ungranted port's ack stays 0.
  - Update last_grant, then go to RECOVER.
- RECOVER:
  - One cycle, both acks 0, no grant. This absorbs the master's access still being high in the cycle after ack.
  - Then go to IDLE.
- Address handling: use data/instr_m_addr[addr_bits:1]. Upper bits are ignored, so addresses alias modulo 2^addr_bits words.
- Writes with bytesel = 2'b00 modify nothing but still complete with ack.
- Access dropped during WAIT is a protocol violation. The transaction still completes: any write commits and ack is pulsed.
- The port that loses arbitration keeps waiting. Its request is re-evaluated at the next IDLE.
- RAM contents are not cleared by reset and are undefined after power-up.

## Timing
- Reset values:
  - instr_m_ack = 0, data_m_ack = 0.
  - instr_m_data_out = 16'h0000, data_m_data_out = 16'h0000.
  - State = IDLE, last_grant = instruction, wait counter = 0.
- Latency: access first high in IDLE cycle T gives ack in cycle T+wait_states+2.
- Throughput: one transaction per wait_states+4 cycles, counting IDLE, WAIT, ACK and RECOVER.
- Data_out registers change only on the edge entering ACK for their own port; they hold otherwise.
- A write to address A followed by a read of A returns the new data; no bypass is needed because of sequencing.
- Reset asserted mid-transaction:
  - Acks and data_out clear immediately, asynchronously.
  - The FSM returns to IDLE.
  - A write not yet at the WAIT→ACK edge is not committed.
- Both access signals low in IDLE: zero activity, outputs hold.

## Test plan
- Reset, then a data write of 16'hBEEF to word 0x00010 with bytesel 2'b11 and wait_states 1 -> data_m_ack pulses once, 3 cycles after access. A read of 0x00010 returns 16'hBEEF.
- A byte-lane write of 16'h12AA to 0x00010 with bytesel 2'b01 -> a later read returns 16'hBEAA. A write with bytesel 2'b00 is acked and leaves the word unchanged.
- Instruction and data requests rise in the same cycle, both held continuously -> data acked first, then instruction, then data; a strict alternation with no second ack for a single request.
- wait_states 0, instruction read of 0x00020 preloaded with 16'h9090 -> instr_m_ack at T+2 with instr_m_data_out = 16'h9090; data_m_ack stays 0.
- addr_bits 10, write 16'h5555 to 0x00005, then read 0x00405 -> returns 16'h5555 (aliasing).
- Reset pulsed during WAIT of a write of 16'hFFFF to 0x00030 (previously 16'h0001):
  - Acks drop immediately and no ack is pulsed.
  - After release, a read of 0x00030 returns 16'h0001.
